// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and the
// bus-timeout counter sizing helper.
`default_nettype none

package mem_defs;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter only has to reach timeout-1, so clog2(timeout) bits suffice.
  function automatic int cnt_width(input int timeout);
    if (timeout < 2) return 1;
    return $clog2(timeout);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_align.sv
// Byte-lane steering: store strobes/replicated data, load lane select with
// sign/zero extension, and the alignment check.
`default_nettype none

module mem_align
  import mem_defs::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    wstrb      = 4'b1111;
    wdata      = store_data;
    misaligned = 1'b0;
    load_data  = rdata;
    case (size)
      MEM_B: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = is_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      MEM_H: begin
        wstrb      = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
        load_data  = is_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      // Word, and the unused encoding 11 which behaves as a word.
      default: misaligned = |addr_lo;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data bus with a req/ack handshake, stalls the
// pipeline until completion and reports misaligned or timed-out accesses.
`default_nettype none

module mem_access_stage
  import mem_defs::*;
#(
  parameter int DBUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipeline_stop_i,
  input  logic        ex_mem_re_i,
  input  logic        ex_mem_we_i,
  input  logic [1:0]  ex_mem_size_i,
  input  logic        ex_mem_unsigned_i,
  input  logic [31:0] ex_alu_i,
  input  logic [31:0] ex_store_data_i,
  input  logic        ex_reg_we_i,
  input  logic [4:0]  ex_wR_i,
  input  logic [31:0] ex_pc4_i_debug,
  input  logic        ex_debug_wb_have_inst_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_wstrb_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        mem_reg_we_o,
  output logic [31:0] mem_wD_o,
  output logic [4:0]  mem_wR_o,
  output logic [31:0] mem_pc4_o_debug,
  output logic        mem_debug_wb_have_inst_o,
  output logic        mem_stall_o,
  output logic        mem_fault_o
);

  localparam int CNT_W = cnt_width(DBUS_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DBUS_TIMEOUT > 0) ? DBUS_TIMEOUT - 1 : 0);

  logic [1:0]       state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      load_q;
  logic             fault_q, fault_pulse;
  logic             req_q, we_q;
  logic [29:0]      addr_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      wdata_q;

  logic [3:0]  align_wstrb;
  logic [31:0] align_wdata, align_load;
  logic        misaligned;
  logic        is_mem, discard, valid_op, misalign_op, timeout_hit;

  mem_align u_align (
    .size        (ex_mem_size_i),
    .is_unsigned (ex_mem_unsigned_i),
    .addr_lo     (ex_alu_i[1:0]),
    .store_data  (ex_store_data_i),
    .rdata       (dbus_rdata_i),
    .wstrb       (align_wstrb),
    .wdata       (align_wdata),
    .load_data   (align_load),
    .misaligned  (misaligned)
  );

  assign is_mem      = ex_mem_re_i | ex_mem_we_i;
  assign discard     = ex_pc4_i_debug[31];
  assign valid_op    = is_mem & ~discard & ~misaligned;
  assign misalign_op = is_mem & ~discard & misaligned;
  assign timeout_hit = (DBUS_TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (valid_op) next_state = ST_BUSY;
      ST_BUSY: if (dbus_ack_i || timeout_hit) next_state = ST_DONE;
      ST_DONE: if (!pipeline_stop_i) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      load_q      <= '0;
      fault_q     <= 1'b0;
      fault_pulse <= 1'b0;
    end else begin
      fault_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_op) begin
            req_q   <= 1'b1;
            we_q    <= ex_mem_we_i;
            addr_q  <= ex_alu_i[31:2];
            wstrb_q <= align_wstrb;
            wdata_q <= align_wdata;
            cnt     <= '0;
            fault_q <= 1'b0;
          end else if (misalign_op && !pipeline_stop_i) begin
            // Pulse once, as the faulting instruction leaves the stage.
            fault_pulse <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (dbus_ack_i) begin
            req_q  <= 1'b0;
            load_q <= align_load;
          end else if (timeout_hit) begin
            req_q       <= 1'b0;
            fault_q     <= 1'b1;
            fault_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_stall_o  = 1'b0;
    mem_reg_we_o = 1'b0;
    mem_wD_o     = ex_alu_i;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          mem_stall_o  = valid_op;
          mem_reg_we_o = ex_reg_we_i & ~is_mem & ~discard;
        end
        ST_BUSY: mem_stall_o = 1'b1;
        ST_DONE: begin
          mem_reg_we_o = ex_reg_we_i & ~fault_q;
          if (ex_mem_re_i) mem_wD_o = load_q;
        end
        default: ;
      endcase
    end
  end

  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = {addr_q, 2'b00};
  assign dbus_wstrb_o = wstrb_q;
  assign dbus_wdata_o = wdata_q;
  assign mem_fault_o  = fault_pulse;

  assign mem_wR_o                 = ex_wR_i;
  assign mem_pc4_o_debug          = ex_pc4_i_debug;
  assign mem_debug_wb_have_inst_o = ex_debug_wb_have_inst_i;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with a short bus timeout.
`default_nettype none

module tb_mem_access_stage;
  import mem_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipeline_stop;
  logic        re, we, uns, reg_we, have_inst;
  logic [1:0]  size;
  logic [31:0] alu, sdata, pc4, rdata;
  logic [4:0]  wr;
  logic        ack;
  logic        dbus_req, dbus_we, mem_reg_we, mem_stall, mem_fault, mem_have;
  logic [31:0] dbus_addr, dbus_wdata, mem_wd, mem_pc4;
  logic [3:0]  dbus_wstrb;
  logic [4:0]  mem_wr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] wd;
    logic        we;
    logic        chk_wd;
    int          stall;
    int          req;
    int          fault;
  } exp_t;
  exp_t exp_q[$];

  mem_access_stage #(.DBUS_TIMEOUT(4)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .pipeline_stop_i          (pipeline_stop),
    .ex_mem_re_i              (re),
    .ex_mem_we_i              (we),
    .ex_mem_size_i            (size),
    .ex_mem_unsigned_i        (uns),
    .ex_alu_i                 (alu),
    .ex_store_data_i          (sdata),
    .ex_reg_we_i              (reg_we),
    .ex_wR_i                  (wr),
    .ex_pc4_i_debug           (pc4),
    .ex_debug_wb_have_inst_i  (have_inst),
    .dbus_req_o               (dbus_req),
    .dbus_we_o                (dbus_we),
    .dbus_addr_o              (dbus_addr),
    .dbus_wstrb_o             (dbus_wstrb),
    .dbus_wdata_o             (dbus_wdata),
    .dbus_ack_i               (ack),
    .dbus_rdata_i             (rdata),
    .mem_reg_we_o             (mem_reg_we),
    .mem_wD_o                 (mem_wd),
    .mem_wR_o                 (mem_wr),
    .mem_pc4_o_debug          (mem_pc4),
    .mem_debug_wb_have_inst_o (mem_have),
    .mem_stall_o              (mem_stall),
    .mem_fault_o              (mem_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_nop();
    re = 1'b0; we = 1'b0; size = MEM_W; uns = 1'b0;
    alu = 32'h0; sdata = 32'h0; reg_we = 1'b0; pc4 = 32'h0;
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_op(
    input string tag, input logic op_re, input logic op_we, input logic [1:0] op_size,
    input logic op_uns, input logic [31:0] addr, input logic [31:0] op_sdata,
    input logic [31:0] op_pc4, input logic op_reg_we, input int ack_at,
    input logic [31:0] op_rdata, input int stops,
    input int e_stall, input int e_req, input int e_fault, input logic chk_wd,
    input logic [31:0] e_wd, input logic e_we, input logic [3:0] e_wstrb,
    input logic [31:0] e_wdata);
    exp_t e;
    int   stall_n, req_n, fault_n;
    bit   done;
    e.wd = e_wd; e.we = e_we; e.chk_wd = chk_wd;
    e.stall = e_stall; e.req = e_req; e.fault = e_fault;
    exp_q.push_back(e);

    re = op_re; we = op_we; size = op_size; uns = op_uns; alu = addr;
    sdata = op_sdata; pc4 = op_pc4; reg_we = op_reg_we;
    wr = addr[4:0] ^ 5'h15; have_inst = 1'b1;
    stall_n = 0; req_n = 0; fault_n = 0; done = 0;

    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      ack = 1'b0;
      fault_n += int'(mem_fault);
      if (!mem_stall) begin
        done = 1;
      end else begin
        stall_n++;
        if (dbus_req) begin
          req_n++;
          if (req_n == 1) begin
            check({tag, ".addr"}, dbus_addr, {addr[31:2], 2'b00});
            check({tag, ".bus_we"}, dbus_we, op_we);
            if (op_we) begin
              check({tag, ".wstrb"}, dbus_wstrb, e_wstrb);
              check({tag, ".wdata"}, dbus_wdata, e_wdata);
            end
          end
          if (req_n == ack_at) begin
            ack = 1'b1;
            rdata = op_rdata;
          end
        end
        @(negedge clk);
      end
    end
    if (!done) check({tag, ".completion_timeout"}, 32'd0, 32'd1);

    if (exp_q.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".stall_cycles"}, stall_n, e.stall);
      check({tag, ".req_cycles"}, req_n, e.req);
      check({tag, ".reg_we"}, mem_reg_we, e.we);
      if (e.chk_wd) check({tag, ".wD"}, mem_wd, e.wd);
      check({tag, ".req_after"}, dbus_req, 1'b0);
      check({tag, ".wR"}, mem_wr, addr[4:0] ^ 5'h15);
      check({tag, ".pc4"}, mem_pc4, op_pc4);
      check({tag, ".have_inst"}, mem_have, 1'b1);

      pipeline_stop = (stops > 0);
      for (int s = 0; s < stops; s++) begin
        @(negedge clk);
        #1;
        fault_n += int'(mem_fault);
        if (e.chk_wd) check({tag, ".wD_held"}, mem_wd, e.wd);
        check({tag, ".req_held"}, dbus_req, 1'b0);
        check({tag, ".stall_held"}, mem_stall, 1'b0);
      end
      pipeline_stop = 1'b0;

      @(negedge clk);
      drive_nop();
      #1;
      fault_n += int'(mem_fault);
      @(negedge clk);
      #1;
      fault_n += int'(mem_fault);
      check({tag, ".fault_pulses"}, fault_n, e.fault);
      check({tag, ".state_idle"}, dut.state, ST_IDLE);
      check({tag, ".req_idle"}, dbus_req, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; pipeline_stop = 1'b0; ack = 1'b0; rdata = 32'h0;
    wr = 5'd0; have_inst = 1'b0;
    drive_nop();
    repeat (3) @(negedge clk);
    #1;
    check("reset.req", dbus_req, 1'b0);
    check("reset.stall", mem_stall, 1'b0);
    check("reset.reg_we", mem_reg_we, 1'b0);
    check("reset.fault", mem_fault, 1'b0);
    check("reset.state", dut.state, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);

    //     tag        re we size  uns addr          sdata         pc4           rwe ack rdata         stp  stall req flt chk wd            we wstrb    wdata
    run_op("lb",      1, 0, MEM_B, 0, 32'h0000_1003, 32'h0,        32'h104,       1, 3, 32'h80FF_0000, 0,  4, 3, 0, 1, 32'hFFFF_FF80, 1, 4'b0000, 32'h0);
    run_op("sh",      0, 1, MEM_H, 0, 32'h0000_2002, 32'h1234_ABCD, 32'h108,      0, 1, 32'h0,         0,  2, 1, 0, 1, 32'h0000_2002, 0, 4'b1100, 32'hABCD_ABCD);
    run_op("lw_mis",  1, 0, MEM_W, 0, 32'h0000_3001, 32'h0,        32'h10C,       1, 0, 32'h0,         0,  0, 0, 1, 1, 32'h0000_3001, 0, 4'b0000, 32'h0);
    run_op("lw_to",   1, 0, MEM_W, 0, 32'h0000_4000, 32'h0,        32'h110,       1, 0, 32'h0,         0,  5, 4, 1, 0, 32'h0,         0, 4'b0000, 32'h0);
    run_op("lhu_stp", 1, 0, MEM_H, 1, 32'h0000_0010, 32'h0,        32'h114,       1, 2, 32'h0000_8001, 2,  3, 2, 0, 1, 32'h0000_8001, 1, 4'b0000, 32'h0);
    run_op("lw_disc", 1, 0, MEM_W, 0, 32'h0000_0020, 32'h0,        32'h8000_0118, 1, 0, 32'h0,         0,  0, 0, 0, 1, 32'h0000_0020, 0, 4'b0000, 32'h0);
    run_op("alu",     0, 0, MEM_W, 0, 32'h1234_5678, 32'h0,        32'h11C,       1, 0, 32'h0,         0,  0, 0, 0, 1, 32'h1234_5678, 1, 4'b0000, 32'h0);
    run_op("lw_race", 1, 0, MEM_W, 0, 32'h0000_0044, 32'h0,        32'h120,       1, 4, 32'hCAFE_F00D, 0,  5, 4, 0, 1, 32'hCAFE_F00D, 1, 4'b0000, 32'h0);
    run_op("sb",      0, 1, MEM_B, 0, 32'h0000_0051, 32'h0000_00A5, 32'h124,      0, 1, 32'h0,         0,  2, 1, 0, 1, 32'h0000_0051, 0, 4'b0010, 32'hA5A5_A5A5);
    run_op("lh",      1, 0, MEM_H, 0, 32'h0000_0062, 32'h0,        32'h128,       1, 2, 32'h9ABC_0000, 0,  3, 2, 0, 1, 32'hFFFF_9ABC, 1, 4'b0000, 32'h0);
    run_op("sw",      0, 1, MEM_W, 0, 32'h0000_0070, 32'hDEAD_BEEF, 32'h12C,      0, 1, 32'h0,         0,  2, 1, 0, 1, 32'h0000_0070, 0, 4'b1111, 32'hDEAD_BEEF);
    run_op("lbu",     1, 0, MEM_B, 1, 32'h0000_0081, 32'h0,        32'h130,       1, 1, 32'h0000_F700, 0,  2, 1, 0, 1, 32'h0000_00F7, 1, 4'b0000, 32'h0);
    run_op("sz3_mis", 1, 0, 2'b11, 0, 32'h0000_0092, 32'h0,        32'h134,       1, 0, 32'h0,         0,  0, 0, 1, 1, 32'h0000_0092, 0, 4'b0000, 32'h0);

    // Reset in the middle of a bus access, followed by a stray ack.
    re = 1'b1; size = MEM_W; alu = 32'h0000_0090; reg_we = 1'b1; pc4 = 32'h138;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_busy.req_before", dbus_req, 1'b1);
    rst = 1'b1;
    drive_nop();
    #1;
    check("rst_busy.stall", mem_stall, 1'b0);
    check("rst_busy.reg_we", mem_reg_we, 1'b0);
    @(negedge clk);
    #1;
    check("rst_busy.req", dbus_req, 1'b0);
    check("rst_busy.state", dut.state, ST_IDLE);
    rst = 1'b0;
    ack = 1'b1;
    rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    ack = 1'b0;
    #1;
    check("late_ack.req", dbus_req, 1'b0);
    check("late_ack.state", dut.state, ST_IDLE);
    check("late_ack.no_capture", dut.load_q, 32'h0);
    check("late_ack.fault", mem_fault, 1'b0);
    check("late_ack.stall", mem_stall, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline. Sits between the EX/MEM register and the MEM/WB register, and feeds that register's mem_* inputs directly.
- Drives the data bus with a req/ack handshake and performs byte-lane alignment for stores and loads, with sign or zero extension for loads.
- Raises mem_stall_o, which is ORed into the global pipeline_stop, until the access has completed.

Parameters:
- DBUS_TIMEOUT, 255: number of BUSY cycles without ack before a bus error is declared. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pipeline_stop_i  in  1  global stall; while high, the MEM/WB register does not advance
- ex_mem_re_i  in  1  load
- ex_mem_we_i  in  1  store
- ex_mem_size_i  in  2  access size: 00 = byte, 01 = half, 10 = word
- ex_mem_unsigned_i  in  1  zero-extend the load result
- ex_alu_i  in  32  ALU result; also the memory address
- ex_store_data_i  in  32  rs2 value
- ex_reg_we_i  in  1  register write enable
- ex_wR_i  in  5  destination register
- ex_pc4_i_debug  in  32  PC+4; bit 31 set means the instruction is discarded
- ex_debug_wb_have_inst_i  in  1  slot holds an instruction
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  bus write
- dbus_addr_o  out  32  word-aligned address ({addr[31:2], 2'b00})
- dbus_wstrb_o  out  4  byte strobes
- dbus_wdata_o  out  32  lane-replicated store data
- dbus_ack_i  in  1  one-cycle completion pulse
- dbus_rdata_i  in  32  read data, valid with ack
- mem_reg_we_o  out  1  to MEM/WB
- mem_wD_o  out  32  to MEM/WB
- mem_wR_o  out  5  to MEM/WB
- mem_pc4_o_debug  out  32  to MEM/WB
- mem_debug_wb_have_inst_o  out  1  to MEM/WB
- mem_stall_o  out  1  request to freeze the pipeline
- mem_fault_o  out  1  one-cycle pulse on misalignment or timeout

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE; dbus_req_o=0, timeout counter=0, load register=0, fault flag=0, mem_fault_o=0.
  - While rst is high, mem_stall_o=0 and mem_reg_we_o=0.
  - A rst during BUSY abandons the access. An ack arriving later in IDLE is ignored.
- An access is a valid op when all of the following hold:
  - (re or we) is set,
  - pc4[31]=0,
  - the address is aligned: half requires addr[0]=0; word requires addr[1:0]=0.
- Misaligned op (in IDLE):
  - No bus cycle.
  - mem_fault_o pulses 1 cycle.
  - mem_reg_we_o=0; no stall.
- Discarded op (pc4[31]=1): no bus cycle, mem_reg_we_o=0, no stall.
- FSM states are IDLE, BUSY, DONE.
- IDLE:
  - A valid op sets mem_stall_o=1 combinationally in the same cycle.
  - Next edge: go to BUSY, register addr/we/wstrb/wdata, set dbus_req_o=1.
  - Non-memory ops pass through with zero added latency: mem_wD_o = ex_alu_i.
- BUSY:
  - dbus_req_o=1; addr, we, wstrb and wdata are held stable; mem_stall_o=1.
  - On dbus_ack_i: capture the aligned and extended rdata, go to DONE, dbus_req_o=0 at that edge.
  - The counter increments each BUSY cycle. At DBUS_TIMEOUT: go to DONE with the fault flag set, pulse mem_fault_o, dbus_req_o=0.
- DONE:
  - mem_stall_o=0.
  - mem_wD_o = captured load data for loads, ex_alu_i otherwise.
  - mem_reg_we_o = ex_reg_we_i AND NOT fault.
  - Go to IDLE at the first edge with pipeline_stop_i=0; stay while pipeline_stop_i=1.
  - Bus is idle in DONE. No second request is issued for the same instruction.
- mem_wR_o, mem_pc4_o_debug and mem_debug_wb_have_inst_o always pass through combinationally.
- Store strobes and data:
  - Byte: wstrb = 1 << addr[1:0], wdata = {4{b}}.
  - Half: wstrb = 0011 << addr[1:0], wdata = {2{h}}.
  - Word: wstrb = 1111.
- Load data:
  - Select the lane by addr[1:0].
  - Sign-extend unless ex_mem_unsigned_i=1.
- Simultaneous ack and timeout in the same cycle: ack wins, no fault.
- Size 11 is illegal: treated as word.

Decomposition:
- Package mem_defs: size encodings (MEM_B, MEM_H, MEM_W), FSM state encodings (ST_IDLE, ST_BUSY, ST_DONE), counter width derived from DBUS_TIMEOUT.
- One combinational sub-module, mem_align: store wstrb/wdata generation, load lane select/extend, and the misalign check.
- The FSM and counter live in the top module.

Test Plan:
- Load byte, signed: lb at addr 0x1003, rdata 0x80FF_0000, ack after 3 cycles → stall high 4 cycles, then mem_wD_o=0xFFFF_FF80, mem_reg_we_o=1.
- Store half: sh at addr 0x2002, data 0x1234_ABCD → dbus_wstrb_o=1100, dbus_wdata_o=0xABCD_ABCD, dbus_addr_o=0x2000, mem_reg_we_o=0.
- Misaligned word: lw at addr 0x3001 → no dbus_req, mem_fault_o pulses 1 cycle, mem_reg_we_o=0, no stall.
- Timeout: DBUS_TIMEOUT=4, lw with ack never arriving → req high exactly 4 cycles, then fault pulse, mem_reg_we_o=0, state returns to IDLE.
- External stall: lhu at 0x10, rdata 0x0000_8001, ack, then pipeline_stop_i=1 for 2 cycles → mem_wD_o held at 0x0000_8001, no new request; IDLE after stop drops.
- Reset and discard: rst asserted during BUSY then late ack → no capture, dbus_req_o=0. Separately, lw with pc4[31]=1 → no bus cycle, mem_reg_we_o=0.
